// File: rtl/sie_transmitter.sv
// Transmit half of the USB serial interface engine: paces line states onto the
// transceiver at FS/LS bit rate and generates bus-reset and resume signalling.
module sie_transmitter #(
    parameter int FS_DIV     = 4,
    parameter int LS_DIV     = 32,
    parameter int RST_CYCLES = 480000,
    parameter int RES_CYCLES = 960000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       fullSpeedRateIn,
    input  logic [1:0] txBitsIn,
    input  logic       txCtrlIn,
    input  logic       txBitsWEn,
    output logic       sieTxRdyOut,
    input  logic [1:0] portCtrlIn,
    input  logic       portCtrlWEn,
    output logic       portCtrlRdyOut,
    output logic [1:0] txWireDataOut,
    output logic       txWireCtrlOut,
    output logic       txWireWEn
);

    localparam logic [2:0] IDLE        = 3'd0;
    localparam logic [2:0] TX_HOLD     = 3'd1;
    localparam logic [2:0] RST_SE0     = 3'd2;
    localparam logic [2:0] RES_K       = 3'd3;
    localparam logic [2:0] RES_EOP_SE0 = 3'd4;
    localparam logic [2:0] RES_EOP_J   = 3'd5;

    localparam logic [7:0]  FS_LOAD      = 8'(FS_DIV - 1);
    localparam logic [7:0]  LS_LOAD      = 8'(LS_DIV - 1);
    localparam logic [19:0] RST_LOAD     = 20'(RST_CYCLES - 1);
    localparam logic [19:0] RES_LOAD     = 20'(RES_CYCLES - 1);
    localparam logic [19:0] EOP_SE0_LOAD = 20'(2 * LS_DIV - 1);
    localparam logic [19:0] EOP_J_LOAD   = 20'(LS_DIV - 1);

    localparam logic [1:0] SE0   = 2'b00;
    localparam logic [1:0] LS_J  = 2'b01;

    logic [2:0]  state;
    logic [7:0]  divCnt;
    logic [19:0] longCnt;
    logic        fsRate;
    logic        bitAccept;
    logic        cmdAccept;

    function automatic logic [1:0] lineJ(input logic fs);
        return fs ? 2'b10 : 2'b01;
    endfunction

    function automatic logic [1:0] lineK(input logic fs);
        return fs ? 2'b01 : 2'b10;
    endfunction

    // Codes 00 and 11 are not commands, so they must not steal a concurrent bit write.
    assign cmdAccept = portCtrlWEn && portCtrlRdyOut &&
                       (portCtrlIn == 2'b01 || portCtrlIn == 2'b10);
    assign bitAccept = txBitsWEn && sieTxRdyOut && !cmdAccept;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state          <= IDLE;
            divCnt         <= '0;
            longCnt        <= '0;
            fsRate         <= 1'b0;
            sieTxRdyOut    <= 1'b1;
            portCtrlRdyOut <= 1'b1;
            txWireDataOut  <= 2'b10;
            txWireCtrlOut  <= 1'b0;
            txWireWEn      <= 1'b0;
        end else begin
            txWireWEn <= 1'b0;
            case (state)
                IDLE, TX_HOLD: begin
                    if (cmdAccept) begin
                        fsRate         <= fullSpeedRateIn;
                        divCnt         <= fullSpeedRateIn ? FS_LOAD : LS_LOAD;
                        sieTxRdyOut    <= 1'b0;
                        portCtrlRdyOut <= 1'b0;
                        txWireCtrlOut  <= 1'b1;
                        txWireWEn      <= 1'b1;
                        if (portCtrlIn == 2'b01) begin
                            txWireDataOut <= SE0;
                            longCnt       <= RST_LOAD;
                            state         <= RST_SE0;
                        end else begin
                            txWireDataOut <= lineK(fullSpeedRateIn);
                            longCnt       <= RES_LOAD;
                            state         <= RES_K;
                        end
                    end else if (bitAccept) begin
                        fsRate        <= fullSpeedRateIn;
                        divCnt        <= fullSpeedRateIn ? FS_LOAD : LS_LOAD;
                        longCnt       <= '0;
                        sieTxRdyOut   <= 1'b0;
                        txWireDataOut <= txBitsIn;
                        txWireCtrlOut <= txCtrlIn;
                        txWireWEn     <= 1'b1;
                        state         <= TX_HOLD;
                    end else if (state == TX_HOLD) begin
                        // Ready is raised for the final cycle so the next bit can follow with no gap.
                        if (divCnt == 8'd0) begin
                            state <= IDLE;
                        end else begin
                            divCnt      <= divCnt - 8'd1;
                            sieTxRdyOut <= (divCnt == 8'd1);
                        end
                    end
                end
                RST_SE0: begin
                    if (longCnt == 20'd0) begin
                        txWireDataOut  <= lineJ(fsRate);
                        txWireCtrlOut  <= 1'b0;
                        txWireWEn      <= 1'b1;
                        sieTxRdyOut    <= 1'b1;
                        portCtrlRdyOut <= 1'b1;
                        divCnt         <= '0;
                        state          <= IDLE;
                    end else begin
                        longCnt <= longCnt - 20'd1;
                    end
                end
                RES_K: begin
                    // The resume EOP is always timed at low speed regardless of the sampled rate.
                    if (longCnt == 20'd0) begin
                        txWireDataOut <= SE0;
                        txWireWEn     <= 1'b1;
                        longCnt       <= EOP_SE0_LOAD;
                        divCnt        <= LS_LOAD;
                        state         <= RES_EOP_SE0;
                    end else begin
                        longCnt <= longCnt - 20'd1;
                    end
                end
                RES_EOP_SE0: begin
                    if (longCnt == 20'd0) begin
                        txWireDataOut <= LS_J;
                        txWireWEn     <= 1'b1;
                        longCnt       <= EOP_J_LOAD;
                        divCnt        <= LS_LOAD;
                        state         <= RES_EOP_J;
                    end else begin
                        longCnt <= longCnt - 20'd1;
                    end
                end
                RES_EOP_J: begin
                    if (longCnt == 20'd0) begin
                        txWireDataOut  <= LS_J;
                        txWireCtrlOut  <= 1'b0;
                        txWireWEn      <= 1'b1;
                        sieTxRdyOut    <= 1'b1;
                        portCtrlRdyOut <= 1'b1;
                        divCnt         <= '0;
                        state          <= IDLE;
                    end else begin
                        longCnt <= longCnt - 20'd1;
                    end
                end
                default: begin
                    state          <= IDLE;
                    sieTxRdyOut    <= 1'b1;
                    portCtrlRdyOut <= 1'b1;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_sie_transmitter.sv
// Self-checking bench for sie_transmitter: random line states and port commands
// compared cycle by cycle against an expected wire trace built from bit-period rules.
module tb_sie_transmitter;

    localparam int FS_DIV     = 4;
    localparam int LS_DIV     = 32;
    localparam int RST_CYCLES = 20;
    localparam int RES_CYCLES = 40;

    logic       clk = 1'b0;
    logic       rst;
    logic       fullSpeedRateIn;
    logic [1:0] txBitsIn;
    logic       txCtrlIn;
    logic       txBitsWEn;
    logic       sieTxRdyOut;
    logic [1:0] portCtrlIn;
    logic       portCtrlWEn;
    logic       portCtrlRdyOut;
    logic [1:0] txWireDataOut;
    logic       txWireCtrlOut;
    logic       txWireWEn;

    // One expected cycle: wire data, output enable, write pulse, bit ready, port ready.
    typedef struct packed {
        logic [1:0] d;
        logic       c;
        logic       w;
        logic       r;
        logic       p;
    } cyc_t;

    cyc_t expQ[$];
    cyc_t obs;
    int   checks   = 0;
    int   failures = 0;

    assign obs = {txWireDataOut, txWireCtrlOut, txWireWEn, sieTxRdyOut, portCtrlRdyOut};

    always #5 clk = ~clk;

    sie_transmitter #(
        .FS_DIV(FS_DIV),
        .LS_DIV(LS_DIV),
        .RST_CYCLES(RST_CYCLES),
        .RES_CYCLES(RES_CYCLES)
    ) dut (
        .clk(clk),
        .rst(rst),
        .fullSpeedRateIn(fullSpeedRateIn),
        .txBitsIn(txBitsIn),
        .txCtrlIn(txCtrlIn),
        .txBitsWEn(txBitsWEn),
        .sieTxRdyOut(sieTxRdyOut),
        .portCtrlIn(portCtrlIn),
        .portCtrlWEn(portCtrlWEn),
        .portCtrlRdyOut(portCtrlRdyOut),
        .txWireDataOut(txWireDataOut),
        .txWireCtrlOut(txWireCtrlOut),
        .txWireWEn(txWireWEn)
    );

    function automatic logic [1:0] jState(input logic fs);
        return fs ? 2'b10 : 2'b01;
    endfunction

    function automatic logic [1:0] kState(input logic fs);
        return fs ? 2'b01 : 2'b10;
    endfunction

    task automatic pushBit(input logic [1:0] d, input logic c, input int div);
        for (int i = 0; i < div; i++)
            expQ.push_back(cyc_t'{d, c, (i == 0), (i == div - 1), 1'b1});
    endtask

    task automatic pushPort(input logic [1:0] d, input logic c, input int len);
        for (int i = 0; i < len; i++)
            expQ.push_back(cyc_t'{d, c, (i == 0), 1'b0, 1'b0});
    endtask

    task automatic pushIdle(input logic [1:0] d, input logic c, input int n, input logic firstPulse);
        for (int i = 0; i < n; i++)
            expQ.push_back(cyc_t'{d, c, (i == 0) && firstPulse, 1'b1, 1'b1});
    endtask

    task automatic test_reset();
        rst = 1'b0;
        #1 rst = 1'b1;
        #1;
        checks++;
        if (obs !== cyc_t'{2'b10, 1'b0, 1'b0, 1'b1, 1'b1}) begin
            failures++;
            $display("[TB] FAIL reset_initial: got %b expected %b", obs, cyc_t'{2'b10, 1'b0, 1'b0, 1'b1, 1'b1});
        end
        @(negedge clk) rst = 1'b0;
        @(posedge clk); #1;
        fullSpeedRateIn = 1'b1; txBitsIn = 2'b01; txCtrlIn = 1'b1; txBitsWEn = 1'b1;
        @(posedge clk); #1;
        txBitsWEn = 1'b0;
        checks++;
        if (obs !== cyc_t'{2'b01, 1'b1, 1'b1, 1'b0, 1'b1}) begin
            failures++;
            $display("[TB] FAIL reset_prebit: got %b expected %b", obs, cyc_t'{2'b01, 1'b1, 1'b1, 1'b0, 1'b1});
        end
        @(negedge clk) rst = 1'b1;
        #1;
        checks++;
        if (obs !== cyc_t'{2'b10, 1'b0, 1'b0, 1'b1, 1'b1}) begin
            failures++;
            $display("[TB] FAIL reset_async: got %b expected %b", obs, cyc_t'{2'b10, 1'b0, 1'b0, 1'b1, 1'b1});
        end
        #2 rst = 1'b0;
        @(posedge clk); #1;
        fullSpeedRateIn = 1'b0; txBitsIn = 2'b11; txCtrlIn = 1'b0; txBitsWEn = 1'b1;
        @(posedge clk); #1;
        txBitsWEn = 1'b0;
        checks++;
        if (obs !== cyc_t'{2'b11, 1'b0, 1'b1, 1'b0, 1'b1}) begin
            failures++;
            $display("[TB] FAIL reset_recover: got %b expected %b", obs, cyc_t'{2'b11, 1'b0, 1'b1, 1'b0, 1'b1});
        end
        repeat (LS_DIV + 8) @(posedge clk);
        #1;
        checks++;
        if (obs !== cyc_t'{2'b11, 1'b0, 1'b0, 1'b1, 1'b1}) begin
            failures++;
            $display("[TB] FAIL reset_recover_idle: got %b expected %b", obs, cyc_t'{2'b11, 1'b0, 1'b0, 1'b1, 1'b1});
        end
    endtask

    task automatic test_stream(input logic fs, input int n);
        logic [1:0] bits[$];
        logic       ctl[$];
        int         div;
        int         nxt;
        div = fs ? FS_DIV : LS_DIV;
        expQ.delete();
        for (int j = 0; j < n; j++) begin
            bits.push_back(2'($urandom));
            ctl.push_back(1'($urandom));
            pushBit(bits[j], ctl[j], div);
        end
        pushIdle(bits[n-1], ctl[n-1], 4, 1'b0);
        fullSpeedRateIn = fs; txBitsIn = bits[0]; txCtrlIn = ctl[0]; txBitsWEn = 1'b1;
        nxt = 1;
        for (int i = 0; i < expQ.size(); i++) begin
            @(posedge clk); #1;
            txBitsWEn = 1'b0;
            fullSpeedRateIn = 1'($urandom); txBitsIn = 2'($urandom); txCtrlIn = 1'($urandom);
            checks++;
            if (obs !== expQ[i]) begin
                failures++;
                $display("[TB] FAIL stream fs=%0d n=%0d cycle %0d: got %b expected %b", fs, n, i, obs, expQ[i]);
            end
            if ((i + 1) % div == 0 && nxt < n) begin
                fullSpeedRateIn = fs; txBitsIn = bits[nxt]; txCtrlIn = ctl[nxt]; txBitsWEn = 1'b1;
                nxt++;
            end
        end
    endtask

    task automatic test_bus_reset(input logic fs);
        expQ.delete();
        pushPort(2'b00, 1'b1, RST_CYCLES);
        pushIdle(jState(fs), 1'b0, 4, 1'b1);
        fullSpeedRateIn = fs; portCtrlIn = 2'b01; portCtrlWEn = 1'b1;
        for (int i = 0; i < expQ.size(); i++) begin
            @(posedge clk); #1;
            portCtrlWEn = 1'b0; txBitsWEn = 1'b0;
            fullSpeedRateIn = 1'($urandom);
            checks++;
            if (obs !== expQ[i]) begin
                failures++;
                $display("[TB] FAIL bus_reset fs=%0d cycle %0d: got %b expected %b", fs, i, obs, expQ[i]);
            end
            if (i == RST_CYCLES / 2) begin
                txBitsIn = 2'($urandom); txBitsWEn = 1'b1;
                portCtrlIn = 2'b10; portCtrlWEn = 1'b1;
            end
        end
    endtask

    task automatic test_resume(input logic fs);
        expQ.delete();
        pushPort(kState(fs), 1'b1, RES_CYCLES);
        pushPort(2'b00, 1'b1, 2 * LS_DIV);
        pushPort(2'b01, 1'b1, LS_DIV);
        pushIdle(2'b01, 1'b0, 4, 1'b1);
        fullSpeedRateIn = fs; portCtrlIn = 2'b10; portCtrlWEn = 1'b1;
        for (int i = 0; i < expQ.size(); i++) begin
            @(posedge clk); #1;
            portCtrlWEn = 1'b0; txBitsWEn = 1'b0;
            fullSpeedRateIn = 1'($urandom);
            checks++;
            if (obs !== expQ[i]) begin
                failures++;
                $display("[TB] FAIL resume fs=%0d cycle %0d: got %b expected %b", fs, i, obs, expQ[i]);
            end
            if (i == RES_CYCLES + 5) begin
                txBitsIn = 2'($urandom); txBitsWEn = 1'b1;
                portCtrlIn = 2'b01; portCtrlWEn = 1'b1;
            end
        end
    endtask

    task automatic test_collision(input logic [1:0] code);
        logic [1:0] b;
        logic       c;
        b = 2'($urandom);
        c = 1'($urandom);
        expQ.delete();
        if (code == 2'b01) begin
            pushPort(2'b00, 1'b1, RST_CYCLES);
            pushIdle(jState(1'b1), 1'b0, 4, 1'b1);
        end else begin
            pushBit(b, c, FS_DIV);
            pushIdle(b, c, 4, 1'b0);
        end
        fullSpeedRateIn = 1'b1; portCtrlIn = code; portCtrlWEn = 1'b1;
        txBitsIn = b; txCtrlIn = c; txBitsWEn = 1'b1;
        for (int i = 0; i < expQ.size(); i++) begin
            @(posedge clk); #1;
            portCtrlWEn = 1'b0; txBitsWEn = 1'b0;
            checks++;
            if (obs !== expQ[i]) begin
                failures++;
                $display("[TB] FAIL collision code=%b cycle %0d: got %b expected %b", code, i, obs, expQ[i]);
            end
        end
    endtask

    initial begin
        fullSpeedRateIn = 1'b1;
        txBitsIn        = 2'b00;
        txCtrlIn        = 1'b0;
        txBitsWEn       = 1'b0;
        portCtrlIn      = 2'b00;
        portCtrlWEn     = 1'b0;
        test_reset();
        test_stream(1'b1, 3);
        test_stream(1'b0, 1);
        test_stream(1'b1, 6);
        test_stream(1'b0, 3);
        test_bus_reset(1'b1);
        test_bus_reset(1'b0);
        test_resume(1'b0);
        test_resume(1'b1);
        test_collision(2'b01);
        test_collision(2'b11);
        test_collision(2'b00);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/sie_transmitter.md
Name: sie_transmitter

Overview:
Transmit half of the USB serial interface engine; it is the outbound counterpart of the SIE line-state receiver. It accepts 2-bit line states one at a time from the upstream bit processor over a ready/write-enable handshake. It holds each line state on the wire for one full-speed or low-speed bit period. It also generates USB bus-reset signalling (SE0) and resume signalling (K, then EOP) on command, and drives the transceiver output-enable.

Parameters:
FS_DIV, 4, clk cycles per full-speed bit (48 MHz clk / 12 Mb/s); must be >= 2
LS_DIV, 32, clk cycles per low-speed bit (48 MHz / 1.5 Mb/s); must be >= 2
RST_CYCLES, 480000, clk cycles of SE0 for bus reset (10 ms); must be < 2^20
RES_CYCLES, 960000, clk cycles of K for resume (20 ms); must be < 2^20

Ports:
clk  in  1  system clock
rst  in  1  reset; asynchronous, active-high
fullSpeedRateIn  in  1  1 = full-speed timing and J/K polarity, 0 = low-speed
txBitsIn  in  2  line state to send: 00 SE0, 01 ZERO_ONE, 10 ONE_ZERO, 11 SE1
txCtrlIn  in  1  output-enable value to apply with txBitsIn
txBitsWEn  in  1  one-cycle strobe; takes effect only while sieTxRdyOut=1
sieTxRdyOut  out  1  transmitter can accept a bit this cycle
portCtrlIn  in  2  01 = bus reset, 10 = resume; 00 and 11 are ignored
portCtrlWEn  in  1  one-cycle strobe; takes effect only while portCtrlRdyOut=1
portCtrlRdyOut  out  1  no port command is in progress
txWireDataOut  out  2  line state driven to the transceiver, bit1 = D+, bit0 = D-
txWireCtrlOut  out  1  transceiver output enable
txWireWEn  out  1  one-cycle pulse whenever txWireDataOut or txWireCtrlOut changes

Behaviour:
- All outputs are registered.
- rst asserted: outputs take their reset values immediately, from any state, and the FSM goes to IDLE.
  - txWireDataOut=10, txWireCtrlOut=0, txWireWEn=0, sieTxRdyOut=1, portCtrlRdyOut=1.
  - Internal counters are cleared.
- J/K mapping: full-speed J=10, K=01; low-speed J=01, K=10.
- fullSpeedRateIn is sampled when a bit or command is accepted and held until that operation ends.
- Counters: divider is 8 bits and loads DIV-1; long counter is 20 bits and loads N-1.
- States: IDLE, TX_HOLD, RST_SE0, RES_K, RES_EOP_SE0, RES_EOP_J.
- IDLE, both strobes in the same cycle: a valid port command wins and the bit is dropped. An ignored command code (00, 11) does not block the bit.
- IDLE, txBitsWEn accepted:
  - Next cycle: txWireDataOut=txBitsIn, txWireCtrlOut=txCtrlIn, txWireWEn=1 for one cycle, sieTxRdyOut=0.
  - Divider loads DIV-1 and the FSM goes to TX_HOLD.
- TX_HOLD:
  - Divider decrements each cycle. sieTxRdyOut is 1 exactly while the divider = 0, i.e. the last cycle of the bit period.
  - txBitsWEn in that cycle loads the next bit with no gap, so a back-to-back stream gives one wire update every DIV cycles.
  - No strobe in that cycle: go to IDLE, keep the last line state, keep sieTxRdyOut=1.
- IDLE, portCtrlWEn with 01 (bus reset):
  - Next cycle: txWireDataOut=00, txWireCtrlOut=1, txWireWEn pulse, sieTxRdyOut=0, portCtrlRdyOut=0.
  - Hold for RST_CYCLES cycles, then drive J with txWireCtrlOut=0 (with WEn pulse) and go to IDLE.
  - Both ready outputs return to 1 on the same cycle as that final wire update.
- IDLE, portCtrlWEn with 10 (resume):
  - Drive K with txWireCtrlOut=1 for RES_CYCLES cycles.
  - Then SE0 for 2*LS_DIV cycles. Resume EOP always uses low-speed timing, independent of fullSpeedRateIn.
  - Then J with txWireCtrlOut=1 for LS_DIV cycles.
  - Then J with txWireCtrlOut=0, return to IDLE, ready outputs to 1. Each line-state change emits one txWireWEn pulse.
- While a port command is in progress, txBitsWEn and portCtrlWEn are ignored.
- sieTxRdyOut is 0 outside IDLE and the final cycle of TX_HOLD.
- The block does not generate EOP for data packets. The upstream bit processor sends SE0, SE0, J as ordinary bits, then J with txCtrlIn=0.
- Counters never wrap; both are reloaded on every state entry.

Test Plan:
- Sim parameters for all tests: FS_DIV=4, LS_DIV=32, RST_CYCLES=20, RES_CYCLES=40.
- Reset: assert rst mid-cycle while in TX_HOLD -> outputs 10/0/0, both ready outputs 1, with no clk edge needed; after release, one bit write is accepted normally.
- FS stream: write 01,10,00 back-to-back on sieTxRdyOut -> txWireDataOut changes at cycles t+1, t+5, t+9; exactly 3 txWireWEn pulses; txWireCtrlOut follows txCtrlIn each time.
- LS single bit then idle: write 10 with fullSpeedRateIn=0 -> sieTxRdyOut low for 31 cycles, high on cycle 32, then stays high; wire holds 10.
- Bus reset at full speed: portCtrlIn=01 -> SE0 with OE=1 for 20 cycles, then 10 with OE=0; txBitsWEn pulsed mid-reset has no effect; portCtrlRdyOut low for exactly 20 cycles.
- Resume at low speed: portCtrlIn=10 -> 10 for 40 cycles, 00 for 64, 01 (OE=1) for 32, then 01 with OE=0; 4 WEn pulses total.
- Simultaneous portCtrlWEn=01 and txBitsWEn in IDLE -> reset sequence runs and the bit is dropped; repeat with portCtrlIn=11 -> the bit is sent.
